// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the decode-stage register file with busy scoreboard.
// Holds the default widths, the zero-register index and a small address helper.
package reg_file_sb_pkg;

  localparam int DEF_DW       = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_AW       = $clog2(DEF_NREGS);
  localparam int DEF_NUM_READ = 2;
  localparam int ZERO_IDX     = 0;

  // True when the hard-wired zero register is enabled and addressed.
  function automatic logic zero_hit(input logic zero_en, input int addr);
    return zero_en && (addr == ZERO_IDX);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-side bus of the register file: read ports, writeback and scoreboard set.
// The master side is decode/issue logic; the slave side is the register file.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int   DW       = DEF_DW,
  parameter int   NREGS    = DEF_NREGS,
  parameter int   NUM_READ = DEF_NUM_READ,
  localparam int  AW       = $clog2(NREGS)
);

  logic [NUM_READ*AW-1:0] read_w;
  logic [NUM_READ*DW-1:0] reg_r;
  logic [NUM_READ-1:0]    busy_r;
  logic                   ctrl_regwrite;
  logic [AW-1:0]          write_w;
  logic [DW-1:0]          write_data_w;
  logic                   sb_set;
  logic [AW-1:0]          sb_set_w;
  logic [AW:0]            pending_cnt;
  logic                   sb_err;

  modport master (
    output read_w, ctrl_regwrite, write_w, write_data_w, sb_set, sb_set_w,
    input  reg_r, busy_r, pending_cnt, sb_err
  );

  modport slave (
    input  read_w, ctrl_regwrite, write_w, write_data_w, sb_set, sb_set_w,
    output reg_r, busy_r, pending_cnt, sb_err
  );

endinterface

// File: rtl/reg_file_sb_bits.sv
// Busy scoreboard: one pending bit per register, a popcount-tracking counter
// and a sticky error for issuing onto an already-pending register.
module reg_file_sb_bits
  import reg_file_sb_pkg::*;
#(
  parameter int  NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pending_cnt,
  output logic             sb_err
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_reg;
  logic [AW:0]      cnt_next;
  logic             err_reg;
  logic             err_next;
  logic             same_addr;
  logic             inc;
  logic             dec;

  // A set on the register being written wins: the new op supersedes the old one.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    logic set_hit;
    logic clr_hit;
    assign set_hit = set_en && (set_addr == AW'(gi));
    assign clr_hit = clr_en && (clr_addr == AW'(gi));
    assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
  end

  assign same_addr = set_en && clr_en && (set_addr == clr_addr);
  assign inc       = set_en && !busy_reg[set_addr];
  assign dec       = clr_en && busy_reg[clr_addr] && !same_addr;

  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (inc && !dec && (cnt_reg != (AW+1)'(NREGS))) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
    if (set_en && busy_reg[set_addr] && !same_addr) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

  assign busy        = busy_reg;
  assign pending_cnt = cnt_reg;
  assign sb_err      = err_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register busy scoreboard and optional
// same-cycle write-to-read bypass, used by decode to read operands and stall.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int  DW       = DEF_DW,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  NUM_READ = DEF_NUM_READ,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  logic [DW-1:0]    mem_reg [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_en;
  logic             set_en;

  // Writes and sets aimed at the hard-wired zero register are dropped here,
  // so neither the array nor the scoreboard ever sees them.
  assign wr_en  = bus.ctrl_regwrite && !zero_hit(ZERO_REG != 0, int'(bus.write_w));
  assign set_en = bus.sb_set && !zero_hit(ZERO_REG != 0, int'(bus.sb_set_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[bus.write_w] <= bus.write_data_w;
    end
  end

  reg_file_sb_bits #(
    .NREGS (NREGS)
  ) u_sb_bits (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (set_en),
    .set_addr    (bus.sb_set_w),
    .clr_en      (wr_en),
    .clr_addr    (bus.write_w),
    .busy        (busy),
    .pending_cnt (bus.pending_cnt),
    .sb_err      (bus.sb_err)
  );

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    logic          byp;

    assign addr = bus.read_w[gi*AW +: AW];
    assign zero = zero_hit(ZERO_REG != 0, int'(addr));
    // Forwarded writeback also reports not-busy, since it clears the pending bit.
    assign byp  = (BYPASS != 0) && bus.ctrl_regwrite && (bus.write_w == addr) && !zero;

    assign bus.reg_r[gi*DW +: DW] = zero ? '0 : (byp ? bus.write_data_w : mem_reg[addr]);
    assign bus.busy_r[gi]         = !zero && !byp && busy[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing instance
// driven with identical stimulus, checked against hand-computed values.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int NR    = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DW(DW), .NREGS(NREGS), .NUM_READ(NR)) bus ();
  reg_file_sb_if #(.DW(DW), .NREGS(NREGS), .NUM_READ(NR)) bus_nb ();

  assign bus_nb.read_w        = bus.read_w;
  assign bus_nb.ctrl_regwrite = bus.ctrl_regwrite;
  assign bus_nb.write_w       = bus.write_w;
  assign bus_nb.write_data_w  = bus.write_data_w;
  assign bus_nb.sb_set        = bus.sb_set;
  assign bus_nb.sb_set_w      = bus.sb_set_w;

  reg_file_sb #(.DW(DW), .NREGS(NREGS), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  reg_file_sb #(.DW(DW), .NREGS(NREGS), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.read_w = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.read_w        = '0;
    bus.ctrl_regwrite = 1'b0;
    bus.write_w       = '0;
    bus.write_data_w  = '0;
    bus.sb_set        = 1'b0;
    bus.sb_set_w      = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Basic write / read on both ports
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd5; bus.write_data_w = 32'hDEADBEEF;
    tick();
    bus.ctrl_regwrite = 1'b0;
    set_rd(5, 5);
    #1;
    check_eq("rd_r5_p0", 64'(bus.reg_r[31:0]), 64'hDEADBEEF);
    check_eq("rd_r5_p1", 64'(bus.reg_r[63:32]), 64'hDEADBEEF);
    check_eq("rd_r5_nb", 64'(bus_nb.reg_r[31:0]), 64'hDEADBEEF);

    // Write to r0 is ignored
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd0; bus.write_data_w = 32'hFFFF_FFFF;
    tick();
    bus.ctrl_regwrite = 1'b0;
    set_rd(0, 0);
    #1;
    check_eq("rd_r0_p0", 64'(bus.reg_r[31:0]), 64'h0);
    check_eq("rd_r0_p1", 64'(bus.reg_r[63:32]), 64'h0);

    // Bypass vs no bypass on r7 (currently 0)
    set_rd(7, 5);
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd7; bus.write_data_w = 32'h1234;
    #1;
    check_eq("byp_r7", 64'(bus.reg_r[31:0]), 64'h1234);
    check_eq("nobyp_r7", 64'(bus_nb.reg_r[31:0]), 64'h0);
    check_eq("byp_other_port", 64'(bus.reg_r[63:32]), 64'hDEADBEEF);
    tick();
    bus.ctrl_regwrite = 1'b0;
    #1;
    check_eq("nobyp_r7_after", 64'(bus_nb.reg_r[31:0]), 64'h1234);

    // Scoreboard: set r3 then r9
    bus.sb_set = 1'b1; bus.sb_set_w = 5'd3;
    tick();
    bus.sb_set_w = 5'd9;
    tick();
    bus.sb_set = 1'b0;
    set_rd(3, 9);
    #1;
    check_eq("cnt_two", 64'(bus.pending_cnt), 64'd2);
    check_eq("busy_r3", 64'(bus.busy_r[0]), 64'd1);
    check_eq("busy_r9", 64'(bus.busy_r[1]), 64'd1);

    // Writeback of r3: bypass clears busy_r in the same cycle
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd3; bus.write_data_w = 32'h33;
    #1;
    check_eq("wb_byp_busy", 64'(bus.busy_r[0]), 64'd0);
    check_eq("wb_nobyp_busy", 64'(bus_nb.busy_r[0]), 64'd1);
    tick();
    bus.ctrl_regwrite = 1'b0;
    #1;
    check_eq("cnt_after_wb", 64'(bus.pending_cnt), 64'd1);
    check_eq("busy_r3_clr", 64'(bus.busy_r[0]), 64'd0);

    // Set r4, then simultaneous set+write r4
    bus.sb_set = 1'b1; bus.sb_set_w = 5'd4;
    tick();
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd4; bus.write_data_w = 32'h4444;
    tick();
    bus.ctrl_regwrite = 1'b0; bus.sb_set = 1'b0;
    set_rd(4, 9);
    #1;
    check_eq("sw_data", 64'(bus.reg_r[31:0]), 64'h4444);
    check_eq("sw_busy", 64'(bus.busy_r[0]), 64'd1);
    check_eq("sw_cnt", 64'(bus.pending_cnt), 64'd2);
    check_eq("sw_err", 64'(bus.sb_err), 64'd0);

    // Set on busy r9 with no write -> sticky error
    bus.sb_set = 1'b1; bus.sb_set_w = 5'd9;
    tick();
    bus.sb_set = 1'b0;
    #1;
    check_eq("err_set", 64'(bus.sb_err), 64'd1);
    check_eq("err_cnt", 64'(bus.pending_cnt), 64'd2);
    check_eq("err_busy_r9", 64'(bus.busy_r[1]), 64'd1);
    tick();
    tick();
    check_eq("err_sticky", 64'(bus.sb_err), 64'd1);

    // Set on r0 is ignored
    bus.sb_set = 1'b1; bus.sb_set_w = 5'd0;
    tick();
    bus.sb_set = 1'b0;
    set_rd(0, 5);
    #1;
    check_eq("set_r0_cnt", 64'(bus.pending_cnt), 64'd2);
    check_eq("set_r0_busy", 64'(bus.busy_r[0]), 64'd0);

    // Write to a non-busy register leaves the count alone
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd5; bus.write_data_w = 32'h5555;
    tick();
    bus.ctrl_regwrite = 1'b0;
    #1;
    check_eq("wr_idle_cnt", 64'(bus.pending_cnt), 64'd2);
    check_eq("wr_idle_data", 64'(bus.reg_r[63:32]), 64'h5555);

    // Asynchronous reset mid-run, checked before any clock edge
    rst_n = 1'b0;
    set_rd(5, 4);
    #1;
    check_eq("rst_data_p0", 64'(bus.reg_r[31:0]), 64'h0);
    check_eq("rst_data_p1", 64'(bus.reg_r[63:32]), 64'h0);
    check_eq("rst_busy", 64'(bus.busy_r), 64'd0);
    check_eq("rst_cnt", 64'(bus.pending_cnt), 64'd0);
    check_eq("rst_err", 64'(bus.sb_err), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Set r10 and write r11 in the same cycle
    bus.sb_set = 1'b1; bus.sb_set_w = 5'd10;
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd11; bus.write_data_w = 32'hAB;
    tick();
    bus.sb_set = 1'b0; bus.ctrl_regwrite = 1'b0;
    set_rd(10, 11);
    #1;
    check_eq("diff_cnt", 64'(bus.pending_cnt), 64'd1);
    check_eq("diff_busy_r10", 64'(bus.busy_r[0]), 64'd1);
    check_eq("diff_data_r11", 64'(bus.reg_r[63:32]), 64'hAB);
    bus.ctrl_regwrite = 1'b1; bus.write_w = 5'd10; bus.write_data_w = 32'h10;
    tick();
    bus.ctrl_regwrite = 1'b0;
    #1;
    check_eq("diff_clr_cnt", 64'(bus.pending_cnt), 64'd0);

    // Full occupancy then full drain
    bus.sb_set = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      bus.sb_set_w = 5'(i);
      tick();
    end
    bus.sb_set = 1'b0;
    #1;
    check_eq("full_cnt", 64'(bus.pending_cnt), 64'(NREGS - 1));
    check_eq("full_err", 64'(bus.sb_err), 64'd0);
    bus.ctrl_regwrite = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      bus.write_w = 5'(i); bus.write_data_w = 32'(i);
      tick();
    end
    #1;
    check_eq("drain_cnt", 64'(bus.pending_cnt), 64'd0);
    bus.write_w = 5'd1;
    tick();
    bus.ctrl_regwrite = 1'b0;
    #1;
    check_eq("no_wrap_cnt", 64'(bus.pending_cnt), 64'd0);
    check_eq("nb_no_wrap_cnt", 64'(bus_nb.pending_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
